// File: rtl/line_delay_reader.sv
// rtl/line_delay_reader.sv - one-line circular delay buffer with FILL/RUN gating and sticky error flags
// Optional err_cnt output when LINE_DELAY_ERRCNT_EN is defined.
module line_delay_reader #(
    parameter int WIDTH    = 11,
    parameter int LINE_LEN = 720,
    parameter int AW       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             line_ready,
    output logic [AW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
`ifdef LINE_DELAY_ERRCNT_EN
    output logic             unf,
    output logic [15:0]      err_cnt
`else
    output logic             unf
`endif
);

    typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(LINE_LEN - 1);
    localparam logic [AW-1:0] LEN_VAL  = AW'(LINE_LEN);

    logic [WIDTH-1:0] mem [0:LINE_LEN-1];

    state_t           state_q, state_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             ovf_q, unf_q;

    logic full_w, empty_w;
    logic rd_acc, wr_acc, wr_drop, rd_rej;

    assign full_w  = (count_q == LEN_VAL);
    assign empty_w = (count_q == '0);

    // A concurrent accepted read frees a slot, so a write at full may proceed.
    always_comb begin
        rd_acc  = rd_en && (state_q == S_RUN) && !empty_w;
        rd_rej  = rd_en && !rd_acc;
        wr_acc  = wr_en && (!full_w || rd_acc);
        wr_drop = wr_en && !wr_acc;
    end

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (wr_acc) wp_d = (wp_q == LAST_IDX) ? '0 : wp_q + 1'b1;
        if (rd_acc) rp_d = (rp_q == LAST_IDX) ? '0 : rp_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (count_d == LEN_VAL) state_d = S_RUN;
            S_RUN:   if (count_d == '0)      state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        line_ready = (state_q == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            if (rd_acc)  rd_data_q <= mem[rp_q];
            if (wr_drop) ovf_q <= 1'b1;
            if (rd_rej)  unf_q <= 1'b1;
        end
    end

    // Storage carries no reset; writes are simply blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem[wp_q] <= wr_data;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

`ifdef LINE_DELAY_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    always_comb begin
        err_inc = {1'b0, wr_drop} + {1'b0, rd_rej};
        err_sum = {1'b0, err_cnt_q} + {15'b0, err_inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/line_delay_reader.md
LINE_DELAY_READER -- requirements
Module: line_delay_reader

Interface
REQ-001 Parameter WIDTH, default 11, pixel width in bits.
REQ-002 Parameter LINE_LEN, default 720, line delay depth in pixels.
REQ-003 Parameter AW, default 10, pointer/count width; 2^AW >= LINE_LEN+1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write strobe; one pixel per asserted cycle.
REQ-007 wr_data  input  WIDTH  pixel written when wr_en=1.
REQ-008 rd_en  input  1  read request from the delayed-line consumer.
REQ-009 rd_data  output  WIDTH  delayed pixel, registered.
REQ-010 rd_valid  output  1  rd_data is new this cycle.
REQ-011 line_ready  output  1  state is RUN.
REQ-012 count  output  AW  pixels stored, 0..LINE_LEN.
REQ-013 full  output  1  count==LINE_LEN.
REQ-014 empty  output  1  count==0.
REQ-015 ovf  output  1  sticky: a write was dropped.
REQ-016 unf  output  1  sticky: a read was rejected.

Function
REQ-017 Storage: LINE_LEN x WIDTH circular buffer with write pointer wp and read pointer rp, each wrapping LINE_LEN-1 -> 0.
REQ-018 States FILL and RUN; FILL -> RUN on the cycle count becomes LINE_LEN; RUN -> FILL on the cycle count becomes 0.
REQ-019 Write accepted when wr_en=1 and (not full or read accepted same cycle): mem[wp]<=wr_data, wp advances.
REQ-020 Write with wr_en=1, full=1 and no accepted read: data dropped, wp and count unchanged, ovf<=1.
REQ-021 Read accepted when rd_en=1, state RUN, and not empty; rp advances.
REQ-022 rd_en=1 in FILL, or in RUN with empty=1: read rejected, rp unchanged, rd_valid stays 0, unf<=1.
REQ-023 Latency: rd_data = mem[rp] and rd_valid=1 exactly one cycle after an accepted read; rd_valid=0 otherwise; rd_data holds its last value when rd_valid=0.
REQ-024 count: +1 on accepted write only, -1 on accepted read only, unchanged for both or neither.
REQ-025 Simultaneous accepted read and write at full: both proceed, count stays LINE_LEN, state stays RUN.
REQ-026 Order: pixels emerge in write order; in steady RUN with wr_en=rd_en=1 each cycle, output pixel equals input pixel from LINE_LEN cycles earlier.
REQ-027 Read of an entry written the same cycle is impossible (buffer non-empty on any accepted read); no write-through bypass required.

Reset
REQ-028 reset=1 at any edge, including mid-line: wp=0, rp=0, count=0, state=FILL, rd_valid=0, rd_data=0, ovf=0, unf=0, full=0, empty=1, line_ready=0.
REQ-029 Memory contents are not cleared by reset; wr_en/rd_en ignored during reset cycles.

Configuration
REQ-030 Macro LINE_DELAY_ERRCNT_EN defined: extra output err_cnt (16 bits) counts each dropped write plus each rejected read, +2 if both in one cycle, saturating at 16'hFFFF, cleared by reset.
REQ-031 Macro LINE_DELAY_ERRCNT_EN undefined: port err_cnt and its logic absent; all other behaviour identical.

Verification
REQ-032 Reset, then 720 writes of values 0..719 with rd_en=0 -> count=720, full=1, line_ready=1 on the cycle after the 720th write; ovf=0, unf=0.
REQ-033 From full, wr_en=rd_en=1 for 1000 cycles writing 720..1719 -> rd_valid=1 each cycle from the second, rd_data sequence 0,1,2,...; count stays 720.
REQ-034 Write 10 pixels, then rd_en=1 -> rd_valid stays 0, unf=1, count=10 (FILL).
REQ-035 From full, one extra write 0x7FF with rd_en=0 -> ovf=1, count=720; drain 720 reads yields 0..719, 0x7FF never appears; line_ready drops when count reaches 0.
REQ-036 Reset asserted after 300 writes -> next cycle count=0, empty=1, state FILL, ovf=unf=0; 720 new writes then reads return the new data from the first new pixel.
REQ-037 With LINE_DELAY_ERRCNT_EN: 3 dropped writes plus 2 rejected reads -> err_cnt=5; without macro, port absent and REQ-032..036 still pass.
